// File: rtl/unpooler.sv
// Nearest-neighbour upsampler. It takes a pooled (m/p)x(m/p) feature map as a raster
// stream and emits the full m x m map. Each pooled row is buffered once and then
// replayed p times, with every value repeated p times along the row.
module unpooler #(
    parameter int unsigned m = 12,  // full map side, a multiple of p
    parameter int unsigned p = 3,   // replication factor per axis
    parameter int unsigned N = 16   // data width, passed through bit-exact
) (
    input  logic         clk,
    input  logic         master_rst,
    input  logic         ce,
    input  logic [N-1:0] data_in,
    input  logic         in_valid,
    output logic         in_ready,
    output logic [N-1:0] data_out,
    output logic         valid_op,
    output logic         end_op
);

    localparam int unsigned W      = m / p;                      // pooled row length
    localparam int unsigned AW     = (W > 1) ? $clog2(W) : 1;    // buffer address width
    localparam int unsigned IDX_W  = $clog2(W) + 1;
    localparam int unsigned SUB_W  = $clog2(p) + 1;
    localparam int unsigned COL_W  = $clog2(m) + 1;

    typedef enum logic {FILL, EMIT} state_t;

    state_t             state;
    logic [IDX_W-1:0]   wr_idx;   // next buffer slot to fill
    logic [SUB_W-1:0]   sub;      // repeat count of the current value along the row
    logic [IDX_W-1:0]   idx;      // buffer slot being replayed
    logic [COL_W-1:0]   col;      // output column
    logic [SUB_W-1:0]   rep;      // replay count of the current pooled row
    logic [IDX_W-1:0]   prow;     // pooled row within the map
    logic               accept;

    logic [N-1:0] row_buf [0:(1<<AW)-1];

    // Input is only taken while filling; ce=0 also blocks acceptance.
    assign in_ready = ce & (state == FILL);
    assign accept   = in_valid & in_ready;

    // Capture one pooled row into the replay buffer.
    // NOTE: the row buffer has no reset; every slot is written before it is read,
    // so leaving it out of the reset keeps it mappable to plain RAM/flops without a reset tree.
    always_ff @(posedge clk) begin
        if (accept) begin
            row_buf[wr_idx[AW-1:0]] <= data_in;
        end
    end

    // Fill/replay sequencer with registered outputs.
    // NOTE: all state is updated with non-blocking assignments so every register
    // samples the pre-edge values, regardless of statement order in this block.
    always_ff @(posedge clk or negedge master_rst) begin
        if (!master_rst) begin
            state    <= FILL;
            wr_idx   <= '0;
            sub      <= '0;
            idx      <= '0;
            col      <= '0;
            rep      <= '0;
            prow     <= '0;
            data_out <= '0;
            valid_op <= 1'b0;
            end_op   <= 1'b0;
        end else if (!ce) begin
            // Frozen: only the per-cycle strobes drop, everything else holds.
            valid_op <= 1'b0;
            end_op   <= 1'b0;
        end else begin
            case (state)
                FILL: begin
                    valid_op <= 1'b0;
                    end_op   <= 1'b0;
                    if (accept) begin
                        if (wr_idx == IDX_W'(W - 1)) begin
                            wr_idx <= '0;
                            state  <= EMIT;
                        end else begin
                            wr_idx <= wr_idx + 1'b1;
                        end
                    end
                end
                EMIT: begin
                    data_out <= row_buf[idx[AW-1:0]];
                    valid_op <= 1'b1;
                    end_op   <= 1'b0;
                    if (col == COL_W'(m - 1)) begin
                        // End of an output row; m is a multiple of p so sub wraps here too.
                        col <= '0;
                        idx <= '0;
                        sub <= '0;
                        if (rep == SUB_W'(p - 1)) begin
                            rep   <= '0;
                            state <= FILL;
                            if (prow == IDX_W'(W - 1)) begin
                                prow   <= '0;
                                end_op <= 1'b1;
                            end else begin
                                prow <= prow + 1'b1;
                            end
                        end else begin
                            rep <= rep + 1'b1;
                        end
                    end else begin
                        col <= col + 1'b1;
                        if (sub == SUB_W'(p - 1)) begin
                            sub <= '0;
                            idx <= idx + 1'b1;
                        end else begin
                            sub <= sub + 1'b1;
                        end
                    end
                end
                default: state <= FILL;
            endcase
        end
    end

endmodule

// File: tb/tb_unpooler.sv
// Directed bench for unpooler with m=12, p=3, N=16 (pooled row length 4).
// Outputs are sampled 1 time unit after each rising edge; inputs change there too.
module tb_unpooler;

    logic        clk;
    logic        master_rst;
    logic        ce;
    logic [15:0] data_in;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] data_out;
    logic        valid_op;
    logic        end_op;

    int checks = 0;
    int errors = 0;

    unpooler #(.m(12), .p(3), .N(16)) dut (
        .clk        (clk),
        .master_rst (master_rst),
        .ce         (ce),
        .data_in    (data_in),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .data_out   (data_out),
        .valid_op   (valid_op),
        .end_op     (end_op)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Assert reset; outputs must clear immediately (async), then hold through an edge.
    task automatic do_reset();
        master_rst = 1'b0;
        #1;
        check("rst_async_data", 32'(data_out), 32'h0);
        check("rst_async_valid", 32'(valid_op), 32'h0);
        check("rst_async_end", 32'(end_op), 32'h0);
        step();
        check("rst_data", 32'(data_out), 32'h0);
        check("rst_valid", 32'(valid_op), 32'h0);
        check("rst_ready", 32'(in_ready), 32'(ce));
        master_rst = 1'b1;
    endtask

    // Present one pooled row; with gap set, in_valid drops for a cycle between values.
    task automatic feed_row(input logic [15:0] v [4], input bit gap);
        for (int i = 0; i < 4; i++) begin
            data_in  = v[i];
            in_valid = 1'b1;
            check("fill_ready", 32'(in_ready), 32'h1);
            step();
            if (gap && i < 3) begin
                in_valid = 1'b0;
                data_in  = 16'hdead;
                step();
                check("gap_valid", 32'(valid_op), 32'h0);
                check("gap_ready", 32'(in_ready), 32'h1);
            end
        end
        in_valid = 1'b0;
        data_in  = 16'h0;
    endtask

    // Expect the 36 outputs of one pooled row: v[c/3] per column, three rows.
    // Optionally drop ce for pause_len cycles before output number pause_at.
    task automatic expect_row(input logic [15:0] v [4], input bit last,
                              input int pause_at, input int pause_len);
        for (int k = 0; k < 36; k++) begin
            if (k == pause_at) begin
                ce = 1'b0;
                for (int j = 0; j < pause_len; j++) begin
                    step();
                    check("pause_valid", 32'(valid_op), 32'h0);
                    check("pause_end", 32'(end_op), 32'h0);
                    check("pause_hold", 32'(data_out), 32'(v[((k - 1) % 12) / 3]));
                    check("pause_ready", 32'(in_ready), 32'h0);
                end
                ce = 1'b1;
            end
            check("emit_ready", 32'(in_ready), 32'h0);
            step();
            check("emit_valid", 32'(valid_op), 32'h1);
            check("emit_data", 32'(data_out), 32'(v[(k % 12) / 3]));
            check("emit_end", 32'(end_op), 32'(last && k == 35));
        end
    endtask

    logic [15:0] row [4];

    initial begin
        master_rst = 1'b1;
        ce         = 1'b1;
        in_valid   = 1'b0;
        data_in    = 16'h0;
        #2;

        // Reset state, then a single row 1,2,3,4 back-to-back.
        do_reset();
        row = '{16'd1, 16'd2, 16'd3, 16'd4};
        feed_row(row, 1'b0);
        expect_row(row, 1'b0, -1, 0);
        step();
        check("row_idle_valid", 32'(valid_op), 32'h0);

        // Two full maps back-to-back, inputs 0..15; end_op only on outputs 144 and 288.
        do_reset();
        for (int mp = 0; mp < 2; mp++) begin
            for (int r = 0; r < 4; r++) begin
                for (int c = 0; c < 4; c++) row[c] = 16'(r * 4 + c);
                feed_row(row, 1'b0);
                expect_row(row, (r == 3), -1, 0);
            end
        end
        step();
        check("map_idle_valid", 32'(valid_op), 32'h0);
        check("map_idle_end", 32'(end_op), 32'h0);

        // ce low for 5 cycles after output 20.
        do_reset();
        row = '{16'd10, 16'd20, 16'd30, 16'd40};
        feed_row(row, 1'b0);
        expect_row(row, 1'b0, 20, 5);

        // in_valid toggling during FILL: only 4 values accepted.
        do_reset();
        row = '{16'd5, 16'd6, 16'd7, 16'd8};
        feed_row(row, 1'b1);
        expect_row(row, 1'b0, -1, 0);

        // Reset mid-EMIT aborts the map; the next inputs form row 0 of a fresh map.
        do_reset();
        row = '{16'd1, 16'd2, 16'd3, 16'd4};
        feed_row(row, 1'b0);
        for (int k = 0; k < 7; k++) begin
            step();
            check("abort_data", 32'(data_out), 32'(row[(k % 12) / 3]));
        end
        do_reset();
        row = '{16'h8001, 16'h7fff, 16'h0000, 16'hffff};
        feed_row(row, 1'b0);
        expect_row(row, 1'b0, -1, 0);
        for (int r = 1; r < 4; r++) begin
            for (int c = 0; c < 4; c++) row[c] = 16'(16'h1000 * r + c);
            feed_row(row, 1'b0);
            expect_row(row, (r == 3), -1, 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
